mem_byte_seq: RTL and testbench



---
 rtl/mem_byte_seq.sv | 155 +++++++++++++++
 tb/tb_mem_byte_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: splits byte/half/word loads and stores into single-byte
// accesses to a byte-wide synchronous RAM. Loads are assembled little-endian
// and then sign- or zero-extended. Misaligned or illegal requests get an
// error response and never reach the RAM.
module mem_byte_seq #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_r_wn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDRAIN,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [2:0]        r_idx;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_req_err;
  logic [2:0]        w_last_idx;
  logic              w_last;
  logic              w_capture;
  logic [1:0]        w_cap_lane;
  logic [31:0]       w_lane_data;
  logic [31:0]       w_ext;

  assign w_accept  = (r_state == S_IDLE) && req_valid;

  // Illegal size, or a half/word whose address is not naturally aligned.
  assign w_req_err = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  assign w_last_idx = (r_size == 2'b00) ? 3'd0 :
                      (r_size == 2'b01) ? 3'd1 : 3'd3;
  assign w_last     = (r_idx == w_last_idx);

  // Read data lags its address by one cycle, so the byte for index i-1 is on
  // ram_dout while RD presents index i; RDRAIN picks up the final byte.
  assign w_capture  = ((r_state == S_RD) && (r_idx != 3'd0)) || (r_state == S_RDRAIN);
  assign w_cap_lane = r_idx[1:0] - 2'd1;

  // Merge the incoming RAM byte into its lane, then extend to 32 bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    w_lane_data = r_rdata;
    w_lane_data[8*w_cap_lane +: 8] = ram_dout;
    case (r_size)
      2'b00:   w_ext = r_uns ? {24'd0, w_lane_data[7:0]}
                             : {{24{w_lane_data[7]}}, w_lane_data[7:0]};
      2'b01:   w_ext = r_uns ? {16'd0, w_lane_data[15:0]}
                             : {{16{w_lane_data[15]}}, w_lane_data[15:0]};
      default: w_ext = w_lane_data;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)   w_next = S_RESP;
          else if (req_we) w_next = S_WR;
          else             w_next = S_RD;
        end
      end
      S_WR:     if (w_last) w_next = S_RESP;
      S_RD:     if (w_last) w_next = S_RDRAIN;
      S_RDRAIN: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: the RAM is only ever written in WR, and idle address/data are 0.
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
    ram_r_wn   = 1'b1;
    ram_addr   = '0;
    ram_din    = 8'd0;
    case (r_state)
      S_WR: begin
        ram_r_wn = 1'b0;
        ram_addr = r_addr + ADDR_W'(r_idx);
        ram_din  = r_wdata[8*r_idx[1:0] +: 8];
      end
      S_RD: ram_addr = r_addr + ADDR_W'(r_idx);
      default: ;
    endcase
  end

  // Request capture, byte index, load assembly and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_idx   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_idx   <= '0;
      r_rdata <= '0;
      r_err   <= w_req_err;
    end else begin
      if ((r_state == S_WR) || (r_state == S_RD)) r_idx <= r_idx + 3'd1;
      if (r_state == S_RDRAIN) r_rdata <= w_ext;
      else if (w_capture)      r_rdata <= w_lane_data;
    end
  end

endmodule

// File: tb/tb_mem_byte_seq.sv
// tb_mem_byte_seq: directed vector table plus hand-written sequences for
// mid-transaction reset and back-to-back requests at the top of memory.
module tb_mem_byte_seq;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              ram_r_wn;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  mem_byte_seq #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_r_wn     (ram_r_wn),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Byte-wide RAM: writes while ram_r_wn=0, read data one cycle after address.
  logic [7:0] mem [4096] = '{default: 8'h00};
  always @(posedge clk) begin
    if (!ram_r_wn) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".ready"},   32'(req_ready),  32'd1);
    check({tag, ".rvalid"},  32'(resp_valid), 32'd0);
    check({tag, ".rdata"},   resp_rdata,      32'd0);
    check({tag, ".rerr"},    32'(resp_err),   32'd0);
    check({tag, ".r_wn"},    32'(ram_r_wn),   32'd1);
    check({tag, ".addr"},    32'(ram_addr),   32'd0);
    check({tag, ".din"},     32'(ram_din),    32'd0);
  endtask

  // One request from an idle DUT; checks write stream, latency and response.
  task automatic run_txn(input vec_t v, input int id);
    int          writes;
    int          lat;
    logic [31:0] wd;
    @(negedge clk);
    check($sformatf("v%0d.ready", id), 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = 32'hFFFF_FFFF;
    writes = 0;
    lat    = 0;
    wd     = v.wdata;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!ram_r_wn) begin
        if (writes < 4) begin
          check($sformatf("v%0d.waddr%0d", id, writes), 32'(ram_addr), 32'(12'(v.addr + 12'(writes))));
          check($sformatf("v%0d.wdin%0d", id, writes), 32'(ram_din), 32'(wd[8*writes +: 8]));
        end
        writes++;
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    check($sformatf("v%0d.lat", id),    32'(lat),      32'(v.exp_lat));
    check($sformatf("v%0d.rdata", id),  resp_rdata,    v.exp_rdata);
    check($sformatf("v%0d.err", id),    32'(resp_err), 32'(v.exp_err));
    check($sformatf("v%0d.nwrites", id), 32'(writes),
          32'((v.we && !v.exp_err) ? nbytes(v.size) : 0));
  endtask

  initial begin
    logic        busy_ready;
    logic        saw_resp;
    int          lat;
    logic [31:0] tp_data [4];

    //          we    size   uns   addr     wdata          exp_rdata      err  lat
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 5};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 6};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 12'h013, 32'h00000000, 32'hFFFFFFDE, 1'b0, 3};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 12'h013, 32'h00000000, 32'h000000DE, 1'b0, 3};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 12'h012, 32'h00000000, 32'hFFFFDEAD, 1'b0, 4};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 12'h012, 32'h00000000, 32'h0000DEAD, 1'b0, 4};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 12'h011, 32'h00000000, 32'h00000000, 1'b1, 1};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 12'h102, 32'h12345678, 32'h00000000, 1'b1, 1};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 12'h000, 32'h00000000, 32'h00000000, 1'b1, 1};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 12'h020, 32'hFFFF8001, 32'h00000000, 1'b0, 3};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 12'h020, 32'h00000000, 32'hFFFF8001, 1'b0, 4};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 12'h022, 32'hAAAAAA7F, 32'h00000000, 1'b0, 2};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 12'h022, 32'h00000000, 32'h0000007F, 1'b0, 3};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 12'h020, 32'h00000000, 32'h007F8001, 1'b0, 6};
    vecs[14] = '{1'b0, 2'b00, 1'b0, 12'h021, 32'h00000000, 32'hFFFFFF80, 1'b0, 3};
    vecs[15] = '{1'b0, 2'b10, 1'b1, 12'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 6};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_txn(vecs[i], i);

    // The rejected word store at 0x102 must not have reached the RAM.
    check("err_store.mem102", 32'({mem[12'h105], mem[12'h104], mem[12'h103], mem[12'h102]}), 32'h0);

    // Word store 0x11223344 @0x020 with reset at the edge ending cycle 2.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 12'h020;
    req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);             // cycle 1
    @(negedge clk);             // cycle 2
    rst_n = 1'b0;
    @(negedge clk);             // cycle after the reset edge
    rst_n = 1'b1;
    check_idle("midrst");
    saw_resp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    check("midrst.no_resp", 32'(saw_resp), 32'd0);
    check("midrst.mem020", 32'(mem[12'h020]), 32'h44);
    check("midrst.mem021", 32'(mem[12'h021]), 32'h33);
    check("midrst.mem022", 32'(mem[12'h022]), 32'h7F);
    check("midrst.mem023", 32'(mem[12'h023]), 32'h00);

    // req_valid held high: store/load/store/load at 0xFFC, junk while busy.
    tp_data[0] = 32'hCAFEF00D;
    tp_data[1] = 32'hCAFEF00D;
    tp_data[2] = 32'h80000001;
    tp_data[3] = 32'h80000001;
    @(negedge clk);
    req_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
      check($sformatf("tp%0d.ready", t), 32'(req_ready), 32'd1);
      req_we       = (t % 2 == 0);
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 12'hFFC;
      req_wdata    = (t % 2 == 0) ? tp_data[t] : 32'h0;
      @(posedge clk);
      #1;
      req_we    = 1'b1;
      req_addr  = 12'h000;
      req_wdata = 32'hFFFF_FFFF;
      busy_ready = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (req_ready) busy_ready = 1'b1;
        if (resp_valid) begin
          lat = c;
          break;
        end
      end
      if (t == 3) req_valid = 1'b0;
      check($sformatf("tp%0d.busy_ready", t), 32'(busy_ready), 32'd0);
      check($sformatf("tp%0d.lat", t), 32'(lat), (t % 2 == 0) ? 32'd5 : 32'd6);
      check($sformatf("tp%0d.rdata", t), resp_rdata, (t % 2 == 0) ? 32'h0 : tp_data[t]);
      check($sformatf("tp%0d.err", t), 32'(resp_err), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("tp.memFFC", 32'({mem[12'hFFF], mem[12'hFFE], mem[12'hFFD], mem[12'hFFC]}), 32'h80000001);
    check("tp.mem000", 32'({mem[12'h003], mem[12'h002], mem[12'h001], mem[12'h000]}), 32'h0);
    check("tp.idle_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
